// File: rtl/credito_pkg.sv
// credito_pkg: states, bill codes/values and drink price table for credito_venda.
package credito_pkg;
  typedef enum logic [1:0] {OCIOSO, ACUMULA, PAGO, DEVOLVE} estado_t;
  localparam logic [2:0] COD_R2 = 3'b001;
  localparam logic [2:0] COD_R5 = 3'b010;
  localparam logic [2:0] COD_R10 = 3'b100;
  localparam logic [7:0] VAL_R2 = 8'd2;
  localparam logic [7:0] VAL_R5 = 8'd5;
  localparam logic [7:0] VAL_R10 = 8'd10;
  localparam logic [7:0] PRECO_0 = 8'd3;
  localparam logic [7:0] PRECO_1 = 8'd4;
  localparam logic [7:0] PRECO_2 = 8'd5;
  localparam logic [7:0] PRECO_3 = 8'd7;
  function automatic logic [7:0] preco_de(input logic [1:0] sel);
    return sel == 2'd0 ? PRECO_0 : sel == 2'd1 ? PRECO_1 : sel == 2'd2 ? PRECO_2 : PRECO_3;
  endfunction
  // Invalid codes map to 0, which doubles as the "not a bill" marker.
  function automatic logic [7:0] valor_de(input logic [2:0] cod);
    return cod == COD_R2 ? VAL_R2 : cod == COD_R5 ? VAL_R5 : cod == COD_R10 ? VAL_R10 : 8'd0;
  endfunction
endpackage

// File: rtl/temp_inatividade.sv
// temp_inatividade: inactivity counter; expira flags the cycle the count reaches LIMITE.
module temp_inatividade #(
  parameter int unsigned LIMITE = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic expira
);
  localparam int W = $clog2(LIMITE + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
  assign expira = !clr && cnt == W'(LIMITE - 1);
endmodule

// File: rtl/credito_venda.sv
// credito_venda: credit accumulator and change-return stage of the vending machine.
// Optional inactivity refund enabled by defining CREDITO_TIMEOUT_EN.
module credito_venda
  import credito_pkg::*;
#(
  parameter int unsigned CRED_MAX = 30,
  parameter int unsigned TIMEOUT_CICLOS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cedula_valid,
  input  logic [2:0] cedula_cod,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancelar,
  input  logic       venda_ok,
  output logic [7:0] credito,
  output logic       valor_verificado,
  output logic       troco_pulso,
  output logic       rejeita,
  output logic       ocupado
);
  estado_t estado, estado_n;
  logic [7:0] preco, preco_n, credito_n, valor;
  logic [8:0] soma;
  logic vv_n, troco_n, rej_n, ocupado_n, aceita, expira;
  assign valor = valor_de(cedula_cod);
  assign soma = {1'b0, credito} + {1'b0, valor};
  assign aceita = cedula_valid && !cancelar && (estado == OCIOSO || estado == ACUMULA) &&
                  valor != 8'd0 && soma <= 9'(CRED_MAX);
`ifdef CREDITO_TIMEOUT_EN
  temp_inatividade #(.LIMITE(TIMEOUT_CICLOS)) u_temp (
    .clk(clk),
    .reset(reset),
    .clr(estado != ACUMULA || cedula_valid || sel_valid || cancelar),
    .expira(expira)
  );
`else
  assign expira = 1'b0 && (TIMEOUT_CICLOS != 0);
`endif
  always_comb begin
    estado_n = estado;
    credito_n = credito;
    preco_n = preco;
    vv_n = valor_verificado;
    troco_n = 1'b0;
    rej_n = cedula_valid && !aceita;
    case (estado)
      OCIOSO:
        if (aceita) begin
          credito_n = soma[7:0];
          estado_n = ACUMULA;
        end
      ACUMULA:
        if (cancelar || expira) begin
          estado_n = DEVOLVE;
          troco_n = 1'b1;
        end else if (aceita) credito_n = soma[7:0];
        else if (!cedula_valid && sel_valid && credito >= preco_de(sel)) begin
          preco_n = preco_de(sel);
          estado_n = PAGO;
          vv_n = 1'b1;
        end
      PAGO:
        if (cancelar) begin
          estado_n = DEVOLVE;
          troco_n = 1'b1;
          vv_n = 1'b0;
        end else if (venda_ok) begin
          credito_n = credito - preco;
          vv_n = 1'b0;
          troco_n = credito_n != 8'd0;
          estado_n = credito_n != 8'd0 ? DEVOLVE : OCIOSO;
        end
      DEVOLVE:
        if (credito == 8'd0) estado_n = OCIOSO;
        else if (troco_pulso) begin
          credito_n = credito - 8'd1;
          estado_n = credito == 8'd1 ? OCIOSO : DEVOLVE;
        end else troco_n = 1'b1;
    endcase
    ocupado_n = estado_n == PAGO || estado_n == DEVOLVE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      estado <= OCIOSO;
      credito <= '0;
      preco <= '0;
      valor_verificado <= 1'b0;
      troco_pulso <= 1'b0;
      rejeita <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      estado <= estado_n;
      credito <= credito_n;
      preco <= preco_n;
      valor_verificado <= vv_n;
      troco_pulso <= troco_n;
      rejeita <= rej_n;
      ocupado <= ocupado_n;
    end
endmodule

// File: doc/credito_venda.md
# credito_venda

Credit accumulator and change-return stage for the drink vending machine. It consumes validated bill strobes from the bill switches and drink selections from the buttons. It asserts `valor_verificado` to the sales state machine once credit covers the selected price. After the sale completes, or on cancel, it pays out the remaining credit as a train of one-unit change pulses. It sits directly upstream of the sales state machine and shares the slow machine clock with the 2/5/15 s timers.

## Interface
- `CRED_MAX`, 30 — credit ceiling in units of R$1; max legal value 255.
- `TIMEOUT_CICLOS`, 15 — inactivity limit in clock cycles, used only with the timeout feature.
- `clk` in 1 — machine clock (slow divided clock); all logic on rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state.
- `cedula_valid` in 1 — one-cycle strobe: a bill was inserted.
- `cedula_cod` in 3 — bill code: 3'b001 = R$2, 3'b010 = R$5, 3'b100 = R$10; any other code is invalid.
- `sel_valid` in 1 — one-cycle strobe: a drink was selected.
- `sel` in 2 — drink index 0..3.
- `cancelar` in 1 — level; user cancel.
- `venda_ok` in 1 — one-cycle strobe from the sales state machine: drink dispensed.
- `credito` out 8 — current credit, binary, in R$1 units.
- `valor_verificado` out 1 — the selected price is covered; sale authorised.
- `troco_pulso` out 1 — one pulse per R$1 returned.
- `rejeita` out 1 — one-cycle pulse: bill refused.
- `ocupado` out 1 — high in PAGO and DEVOLVE.

## Operation
- States: OCIOSO, ACUMULA, PAGO, DEVOLVE.
- Prices: index 0 = 3, 1 = 4, 2 = 5, 3 = 7.
- Bill acceptance in OCIOSO or ACUMULA:
  - A bill is accepted if its code is valid and `credito + valor <= CRED_MAX`. Credit is increased and the state moves to ACUMULA.
  - Otherwise `rejeita` pulses and credit is unchanged.
- In PAGO or DEVOLVE every bill is refused (`rejeita` pulses).
- Selection in ACUMULA:
  - If `sel_valid` and `credito >= preco[sel]`: latch the price, go to PAGO, assert `valor_verificado`.
  - If credit is insufficient, the selection is ignored.
  - `sel_valid` in OCIOSO is ignored.
- PAGO:
  - On `venda_ok`: `credito <= credito - preco`, deassert `valor_verificado`.
  - Next state is DEVOLVE if the remainder is > 0, else OCIOSO.
- `cancelar` in ACUMULA or PAGO, before `venda_ok`: go to DEVOLVE with the full credit and drop `valor_verificado`.
- `cancelar` in OCIOSO or DEVOLVE has no effect.
- DEVOLVE:
  - `troco_pulso` alternates high one cycle, low one cycle. Each high cycle decrements `credito` by 1.
  - When credit reaches 0, the next state is OCIOSO.
- Priority within one cycle: `cancelar` > `venda_ok` > `cedula_valid` > `sel_valid`. A bill arriving in the same cycle as a cancel is refused (`rejeita` pulses). A selection coinciding with a bill is dropped.
- Credit arithmetic uses 9-bit compares so the `CRED_MAX` check cannot wrap. Credit never underflows.

## Timing
- Reset values: state OCIOSO, `credito` = 0, `valor_verificado` = 0, `troco_pulso` = 0, `rejeita` = 0, `ocupado` = 0.
- Reset mid-payout aborts the payout immediately. Credit is lost by design.
- `credito` reflects an accepted bill one cycle after the strobe. `rejeita` is high in the cycle after the strobe.
- `valor_verificado` rises one cycle after an accepted `sel_valid` and falls one cycle after `venda_ok` or a cancel.
- The first `troco_pulso` occurs in the first cycle in DEVOLVE. N units of change take 2N cycles.
- All outputs are registered.

## Configuration
- `CREDITO_TIMEOUT_EN` defined:
  - In ACUMULA, a counter increments every cycle with no `cedula_valid`, `sel_valid` or `cancelar`, and any such event clears it.
  - When the counter reaches `TIMEOUT_CICLOS`, the block enters DEVOLVE exactly as if cancelled.
  - The counter is held at 0 outside ACUMULA.
- `CREDITO_TIMEOUT_EN` undefined: no counter; credit is held indefinitely in ACUMULA.

## Structure
- Package `credito_pkg`: state enum, bill codes and their values, the price table as 4 constants, and a `preco_de(sel)` function.
- One sub-module, `temp_inatividade`: a parameterised inactivity counter with clear, present only under `CREDITO_TIMEOUT_EN`.

## Test plan
- Insert R$5, select drink 0 (price 3), pulse `venda_ok` → `credito` 5 → 2, `valor_verificado` high until `venda_ok`, exactly 2 `troco_pulso` highs, then OCIOSO with `credito` = 0.
- Insert R$2, select drink 3 (price 7) → no state change, `valor_verificado` stays 0. Then insert R$5 and select drink 3 → PAGO. `venda_ok` → credit 0, straight to OCIOSO, no `troco_pulso`.
- Insert 10 + 10 + 10 with `CRED_MAX` = 30, then R$2 → `credito` = 30, `rejeita` pulses once. Invalid code 3'b011 → `rejeita` pulses, credit unchanged.
- In PAGO with credit 7, assert `cancelar` in the same cycle as `venda_ok` → cancel wins: 7 change pulses over 14 cycles.
- Assert `reset` during DEVOLVE after 1 of 4 pulses → all outputs 0 in the same cycle, state OCIOSO.
- With `CREDITO_TIMEOUT_EN` and `TIMEOUT_CICLOS` = 15: insert R$2, then idle → DEVOLVE entered 15 cycles after the last event, 2 pulses. A bill at cycle 14 restarts the count.
